// File: rtl/uart_tx_ctrl_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register offsets
// and the transmit FSM state type.
package uart_tx_ctrl_pkg;

   localparam logic [3:0] UART_TXDATA  = 4'h0;
   localparam logic [3:0] UART_STATUS  = 4'h4;
   localparam logic [3:0] UART_BAUDDIV = 4'h8;
   localparam logic [3:0] UART_CTRL    = 4'hC;

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_STOP
   } uart_tx_state_t;

endpackage

// File: rtl/uart_tx_ctrl_fifo.sv
// First-word-fall-through synchronous FIFO; pointers carry one extra wrap bit
// so full and empty are told apart without a separate counter.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic             do_push;
   logic             do_pop;

   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) begin
         mem_d[wr_ptr_q[AW-1:0]] = wdata;
         wr_ptr_d                = wr_ptr_q + (AW+1)'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
      mem_q <= mem_d;
   end

endmodule

// File: rtl/uart_tx_ctrl.sv
// Memory-mapped UART transmit controller: register decode, TX FIFO, baud
// down-counter and an 8N1 serialiser FSM.
module uart_tx_ctrl
   import uart_tx_ctrl_pkg::*;
#(
   parameter int          FIFO_DEPTH  = 8,
   parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        uart_sel,
   input  logic        uart_wr_enable,
   input  logic [3:0]  uart_addr,
   input  logic [31:0] uart_wdata,
   output logic [31:0] uart_rdata,
   output logic        tx,
   output logic        tx_irq
);

   uart_tx_state_t state_q, state_d;
   logic [15:0]    cnt_q, cnt_d;
   logic [2:0]     bit_idx_q, bit_idx_d;
   logic [7:0]     shift_q, shift_d;
   logic [15:0]    baud_div_q, baud_div_d;
   logic           overflow_q, overflow_d;
   logic           tx_en_q, tx_en_d;
   logic           irq_en_q, irq_en_d;

   logic           wr_en;
   logic           push;
   logic           pop;
   logic [7:0]     fifo_rdata;
   logic           fifo_full;
   logic           fifo_empty;
   logic           busy;
   logic           unused_wdata;

   assign wr_en        = uart_sel & uart_wr_enable;
   // A push against a full FIFO is rejected even if the FSM pops this cycle.
   assign push         = wr_en & (uart_addr == UART_TXDATA) & ~fifo_full;
   assign busy         = (state_q != TX_IDLE);
   assign tx_irq       = irq_en_q & fifo_empty & ~busy;
   assign unused_wdata = ^uart_wdata[31:16];

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .wdata (uart_wdata[7:0]),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_comb begin
      overflow_d = overflow_q;
      baud_div_d = baud_div_q;
      tx_en_d    = tx_en_q;
      irq_en_d   = irq_en_q;
      if (wr_en) begin
         case (uart_addr)
            UART_TXDATA:  if (fifo_full) overflow_d = 1'b1;
            UART_STATUS:  overflow_d = 1'b0;
            UART_BAUDDIV: baud_div_d = uart_wdata[15:0];
            UART_CTRL: begin
               tx_en_d  = uart_wdata[0];
               irq_en_d = uart_wdata[1];
            end
            default: ;
         endcase
      end
   end

   // Each bit lasts cnt = DIV..0; the reload at every bit boundary picks up
   // the current divisor, so a mid-frame change never shortens the live bit.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      pop       = 1'b0;
      case (state_q)
         TX_IDLE: begin
            if (tx_en_q && !fifo_empty) begin
               pop     = 1'b1;
               shift_d = fifo_rdata;
               cnt_d   = baud_div_q;
               state_d = TX_START;
            end
         end
         TX_START: begin
            if (cnt_q == 16'd0) begin
               cnt_d     = baud_div_q;
               bit_idx_d = 3'd0;
               state_d   = TX_DATA;
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         TX_DATA: begin
            if (cnt_q == 16'd0) begin
               cnt_d   = baud_div_q;
               shift_d = {1'b0, shift_q[7:1]};
               if (bit_idx_q == 3'd7) begin
                  state_d = TX_STOP;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         TX_STOP: begin
            if (cnt_q == 16'd0) begin
               state_d = TX_IDLE;
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         default: state_d = TX_IDLE;
      endcase
   end

   always_comb begin
      tx = 1'b1;
      case (state_q)
         TX_START: tx = 1'b0;
         TX_DATA:  tx = shift_q[0];
         default:  tx = 1'b1;
      endcase
   end

   always_comb begin
      uart_rdata = 32'd0;
      case (uart_addr)
         UART_STATUS:  uart_rdata = {28'd0, overflow_q, fifo_empty, fifo_full, busy};
         UART_BAUDDIV: uart_rdata = {16'd0, baud_div_q};
         UART_CTRL:    uart_rdata = {30'd0, irq_en_q, tx_en_q};
         default:      uart_rdata = 32'd0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= TX_IDLE;
         cnt_q      <= 16'd0;
         bit_idx_q  <= 3'd0;
         shift_q    <= 8'd0;
         baud_div_q <= DEFAULT_DIV;
         overflow_q <= 1'b0;
         tx_en_q    <= 1'b1;
         irq_en_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bit_idx_q  <= bit_idx_d;
         shift_q    <= shift_d;
         baud_div_q <= baud_div_d;
         overflow_q <= overflow_d;
         tx_en_q    <= tx_en_d;
         irq_en_q   <= irq_en_d;
      end
   end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: directed scenarios plus random register traffic, all
// checked every cycle against a frame-level model of the transmitter.
module tb_uart_tx_ctrl;

   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        uart_sel = 1'b0;
   logic        uart_wr_enable = 1'b0;
   logic [3:0]  uart_addr = 4'h0;
   logic [31:0] uart_wdata = 32'd0;
   logic [31:0] uart_rdata;
   logic        tx;
   logic        tx_irq;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   uart_tx_ctrl dut (
      .clk            (clk),
      .rst            (rst),
      .uart_sel       (uart_sel),
      .uart_wr_enable (uart_wr_enable),
      .uart_addr      (uart_addr),
      .uart_wdata     (uart_wdata),
      .uart_rdata     (uart_rdata),
      .tx             (tx),
      .tx_irq         (tx_irq)
   );

   // Model: a byte queue plus the frame being sent, as a 10-symbol sequence
   // (start, 8 data LSB first, stop) with a per-symbol remaining-cycle count.
   logic [7:0]  exp_q[$];
   logic        m_valid = 1'b0;
   logic        m_ovf, m_en, m_ie, m_active;
   logic [15:0] m_div;
   logic [7:0]  m_cur;
   int          m_k, m_rem;

   task automatic model_step();
      int          old_cnt;
      logic [15:0] old_div;
      logic        old_en;
      if (rst) begin
         exp_q.delete();
         m_ovf = 1'b0; m_div = 16'd433; m_en = 1'b1; m_ie = 1'b0;
         m_active = 1'b0; m_k = 0; m_rem = 0; m_cur = 8'd0;
         m_valid = 1'b1;
      end else if (m_valid) begin
         old_div = m_div;
         old_en  = m_en;
         old_cnt = exp_q.size();
         if (m_active) begin
            m_rem = m_rem - 1;
            if (m_rem == 0) begin
               m_k = m_k + 1;
               if (m_k == 10) m_active = 1'b0;
               else m_rem = int'(old_div) + 1;
            end
         end else if (old_en && exp_q.size() != 0) begin
            m_cur = exp_q.pop_front();
            m_active = 1'b1; m_k = 0; m_rem = int'(old_div) + 1;
         end
         if (uart_sel && uart_wr_enable) begin
            case (uart_addr)
               4'h0: if (old_cnt == DEPTH) m_ovf = 1'b1; else exp_q.push_back(uart_wdata[7:0]);
               4'h4: m_ovf = 1'b0;
               4'h8: m_div = uart_wdata[15:0];
               4'hC: begin m_en = uart_wdata[0]; m_ie = uart_wdata[1]; end
               default: ;
            endcase
         end
      end
   endtask

   function automatic logic exp_tx();
      if (!m_active) return 1'b1;
      if (m_k == 0) return 1'b0;
      if (m_k == 9) return 1'b1;
      return m_cur[m_k-1];
   endfunction

   function automatic logic [31:0] exp_rdata(input logic [3:0] a);
      logic e, f;
      e = (exp_q.size() == 0);
      f = (exp_q.size() == DEPTH);
      case (a)
         4'h4:    return {28'd0, m_ovf, e, f, m_active};
         4'h8:    return {16'd0, m_div};
         4'hC:    return {30'd0, m_ie, m_en};
         default: return 32'd0;
      endcase
   endfunction

   always @(posedge clk) model_step();

   always @(negedge clk) begin
      #1;
      if (m_valid) begin
         checks = checks + 3;
         if (tx !== exp_tx()) begin
            errors++;
            $display("FAIL model_tx got %0b exp %0b at %0t", tx, exp_tx(), $time);
         end
         if (tx_irq !== (m_ie & (exp_q.size() == 0) & ~m_active)) begin
            errors++;
            $display("FAIL model_irq got %0b exp %0b at %0t", tx_irq,
                     m_ie & (exp_q.size() == 0) & ~m_active, $time);
         end
         if (uart_rdata !== exp_rdata(uart_addr)) begin
            errors++;
            $display("FAIL model_rdata addr %0h got %08h exp %08h at %0t", uart_addr,
                     uart_rdata, exp_rdata(uart_addr), $time);
         end
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %08h exp %08h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic wr(input logic [3:0] a, input logic [31:0] d);
      @(negedge clk);
      uart_sel = 1'b1; uart_wr_enable = 1'b1; uart_addr = a; uart_wdata = d;
      @(negedge clk);
      uart_sel = 1'b0; uart_wr_enable = 1'b0;
   endtask

   task automatic rd_check(input string name, input logic [3:0] a, input logic [31:0] exp);
      @(negedge clk);
      uart_sel = 1'b0; uart_wr_enable = 1'b0; uart_addr = a;
      #1;
      check(name, uart_rdata, exp);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         uart_sel = 1'b0; uart_wr_enable = 1'b0;
         uart_addr = 4'($urandom_range(0, 15));
      end
   endtask

   initial begin
      logic [9:0] frame_55;
      int         r;
      bit         drained;

      // Reset values
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_tx", {31'd0, tx}, 32'd1);
      rd_check("rst_bauddiv", 4'h8, 32'd433);
      rd_check("rst_ctrl", 4'hC, 32'd1);
      rd_check("rst_status", 4'h4, 32'h4);
      check("rst_irq", {31'd0, tx_irq}, 32'd0);

      // Single 0x55 frame at DIV=3: start, 1010_1010 LSB first, stop; 4 clk each
      wr(4'h8, 32'd3);
      wr(4'h0, 32'h55);
      uart_addr = 4'h4;
      frame_55 = 10'b1_0101_0101_0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk); #1;
         check("t1_tx", {31'd0, tx}, {31'd0, frame_55[i/4]});
         check("t1_busy", {31'd0, uart_rdata[0]}, 32'd1);
      end
      @(negedge clk); #1;
      check("t1_tx_idle", {31'd0, tx}, 32'd1);
      check("t1_busy_end", {31'd0, uart_rdata[0]}, 32'd0);

      // Back-to-back frames
      wr(4'h0, 32'hA3);
      wr(4'h0, 32'h0F);
      idle(95);

      // Fill with transmitter disabled, overflow, clear
      wr(4'hC, 32'd0);
      for (int i = 0; i < DEPTH; i++) wr(4'h0, 32'h10 + i);
      rd_check("t3_full", 4'h4, 32'h2);
      wr(4'h0, 32'hEE);
      rd_check("t3_overflow", 4'h4, 32'hA);
      wr(4'h4, 32'hFFFF_FFFF);
      rd_check("t3_cleared", 4'h4, 32'h2);

      // Drain with irq enabled
      wr(4'hC, 32'd3);
      drained = 1'b0;
      for (int i = 0; i < 600 && !drained; i++) begin
         @(negedge clk);
         uart_addr = 4'h4;
         #1;
         if (uart_rdata == 32'h4) drained = 1'b1;
      end
      check("t4_drain_done", {31'd0, drained}, 32'd1);
      rd_check("t4_status", 4'h4, 32'h4);
      check("t4_irq_on", {31'd0, tx_irq}, 32'd1);
      wr(4'hC, 32'd1);
      #1;
      check("t4_irq_off", {31'd0, tx_irq}, 32'd0);

      // Divisor change mid-frame, then reset mid-DATA
      wr(4'h0, 32'h3C);
      idle(6);
      wr(4'h8, 32'd7);
      idle(20);
      @(negedge clk);
      rst = 1'b1; uart_addr = 4'h4;
      @(negedge clk); #1;
      check("t5_rst_tx", {31'd0, tx}, 32'd1);
      check("t5_rst_status", uart_rdata, 32'h4);
      rst = 1'b0;

      // Unselected write is ignored
      wr(4'h8, 32'd3);
      @(negedge clk);
      uart_sel = 1'b0; uart_wr_enable = 1'b1; uart_addr = 4'h0; uart_wdata = 32'h99;
      rd_check("t6_status", 4'h4, 32'h4);
      rd_check("t6_bauddiv", 4'h8, 32'd3);
      idle(3);

      // Random register traffic
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         rst = ($urandom_range(0, 999) == 0);
         uart_sel = ($urandom_range(0, 3) != 0);
         uart_wr_enable = ($urandom_range(0, 2) == 0);
         r = $urandom_range(0, 9);
         if (r <= 4) uart_addr = 4'h0;
         else if (r == 5) uart_addr = 4'h4;
         else if (r == 6) uart_addr = 4'h8;
         else if (r == 7) uart_addr = 4'hC;
         else uart_addr = 4'($urandom_range(0, 15));
         uart_wdata = $urandom;
         if (uart_addr == 4'h8) uart_wdata[15:0] = 16'($urandom_range(0, 4));
         if (uart_addr == 4'hC) uart_wdata[0] = ($urandom_range(0, 4) != 0);
      end
      @(negedge clk);
      rst = 1'b0; uart_sel = 1'b0; uart_wr_enable = 1'b0;
      idle(5);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
